// File: rtl/alu_mdu_control.sv
// EX-stage ALU operation decoder with an iterative unsigned multiply/divide unit.
// The multiply/divide unit shift-adds or restoring-divides one bit per cycle and stalls the pipeline while busy.
module alu_mdu_control #(
  parameter int XLEN = 64
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  input  logic            i_flush,
  input  logic [1:0]      i_ALUOp,
  input  logic            i_inst30,
  input  logic            i_inst25,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  output logic [3:0]      o_ALU_Optype,
  output logic            o_stall,
  output logic            o_md_valid,
  output logic [XLEN-1:0] o_md_result
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t          state_reg;
  logic [CW-1:0]   count_reg;
  logic            op_hi_reg;     // MULHU / REMU select the upper half
  logic [XLEN-1:0] operand_reg;   // multiplicand or divisor
  logic [XLEN-1:0] acc_hi_reg;    // product high half or partial remainder
  logic [XLEN-1:0] acc_lo_reg;    // multiplier or dividend/quotient
  logic [XLEN-1:0] md_result_reg;

  logic            md_legal;
  logic            request;
  logic            last_step;
  logic [XLEN:0]   mul_sum;
  logic [XLEN-1:0] mul_hi_next;
  logic [XLEN-1:0] mul_lo_next;
  logic [XLEN:0]   rem_shift;
  logic [XLEN:0]   trial;
  logic [XLEN-1:0] div_hi_next;
  logic [XLEN-1:0] div_lo_next;

  assign md_legal = (i_funct3 == 3'b000) || (i_funct3 == 3'b011) ||
                    (i_funct3 == 3'b101) || (i_funct3 == 3'b111);

  assign request = i_valid && (i_ALUOp == 2'b10) && i_inst25 && md_legal &&
                   (state_reg == IDLE) && !i_flush;

  assign last_step = (count_reg == CW'(XLEN - 1));

  always_comb begin
    o_ALU_Optype = 4'b1111;
    case (i_ALUOp)
      2'b00: o_ALU_Optype = 4'b0010;
      2'b01: o_ALU_Optype = 4'b0110;
      2'b10: begin
        if (i_inst25) begin
          o_ALU_Optype = md_legal ? 4'b1000 : 4'b1111;
        end else begin
          case ({i_inst30, i_funct3})
            4'b0000: o_ALU_Optype = 4'b0010;
            4'b1000: o_ALU_Optype = 4'b0110;
            4'b0111: o_ALU_Optype = 4'b0000;
            4'b0110: o_ALU_Optype = 4'b0001;
            4'b0100: o_ALU_Optype = 4'b0011;
            4'b0001: o_ALU_Optype = 4'b0100;
            4'b0101: o_ALU_Optype = 4'b0101;
            4'b1101: o_ALU_Optype = 4'b0111;
            default: o_ALU_Optype = 4'b1111;
          endcase
        end
      end
      2'b11: begin
        case (i_funct3)
          3'b000:  o_ALU_Optype = 4'b0010;
          3'b111:  o_ALU_Optype = 4'b0000;
          3'b110:  o_ALU_Optype = 4'b0001;
          3'b100:  o_ALU_Optype = 4'b0011;
          3'b001:  o_ALU_Optype = 4'b0100;
          3'b101:  o_ALU_Optype = i_inst30 ? 4'b0111 : 4'b0101;
          default: o_ALU_Optype = 4'b1111;
        endcase
      end
      default: o_ALU_Optype = 4'b1111;
    endcase
  end

  // Shift-add step: conditionally add the multiplicand to the high half, then shift right with carry.
  assign mul_sum     = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, operand_reg} : '0);
  assign mul_hi_next = mul_sum[XLEN:1];
  assign mul_lo_next = {mul_sum[0], acc_lo_reg[XLEN-1:1]};

  // Restoring step: the sign bit of the trial subtraction decides the quotient bit.
  assign rem_shift   = {acc_hi_reg, acc_lo_reg[XLEN-1]};
  assign trial       = rem_shift - {1'b0, operand_reg};
  assign div_hi_next = trial[XLEN] ? rem_shift[XLEN-1:0] : trial[XLEN-1:0];
  assign div_lo_next = {acc_lo_reg[XLEN-2:0], ~trial[XLEN]};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      op_hi_reg     <= 1'b0;
      operand_reg   <= '0;
      acc_hi_reg    <= '0;
      acc_lo_reg    <= '0;
      md_result_reg <= '0;
    end else if (i_flush) begin
      state_reg <= IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (request) begin
            op_hi_reg  <= i_funct3[1];
            count_reg  <= '0;
            acc_hi_reg <= '0;
            if (!i_funct3[2]) begin
              state_reg   <= MUL;
              operand_reg <= i_rs1;
              acc_lo_reg  <= i_rs2;
            end else if (i_rs2 == '0) begin
              state_reg     <= DONE;
              md_result_reg <= i_funct3[1] ? i_rs1 : '1;
            end else begin
              state_reg   <= DIV;
              operand_reg <= i_rs2;
              acc_lo_reg  <= i_rs1;
            end
          end
        end
        MUL: begin
          acc_hi_reg <= mul_hi_next;
          acc_lo_reg <= mul_lo_next;
          count_reg  <= count_reg + CW'(1);
          if (last_step) begin
            state_reg     <= DONE;
            md_result_reg <= op_hi_reg ? mul_hi_next : mul_lo_next;
          end
        end
        DIV: begin
          acc_hi_reg <= div_hi_next;
          acc_lo_reg <= div_lo_next;
          count_reg  <= count_reg + CW'(1);
          if (last_step) begin
            state_reg     <= DONE;
            md_result_reg <= op_hi_reg ? div_hi_next : div_lo_next;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign o_md_valid  = (state_reg == DONE) && !i_flush;
  assign o_stall     = !i_flush && (request || (state_reg == MUL) || (state_reg == DIV));
  assign o_md_result = md_result_reg;

endmodule

// File: doc/alu_mdu_control.md
ALU_MDU_CONTROL -- requirements
Module: alu_mdu_control

Interface
REQ-001 Parameter XLEN, default 64, operand/result width in bits; legal values 8..64, even.
REQ-002 i_clk  in  1  sole clock; all state updates on rising edge.
REQ-003 i_rst  in  1  synchronous reset, active-high.
REQ-004 i_valid  in  1  EX-stage instruction valid.
REQ-005 i_flush  in  1  abort any in-flight MDU operation.
REQ-006 i_ALUOp  in  2  00 load/store, 01 branch, 10 R-type, 11 I-type.
REQ-007 i_inst30  in  1  instruction bit 30.
REQ-008 i_inst25  in  1  instruction bit 25 (funct7[0], M-extension select).
REQ-009 i_funct3  in  3  instruction funct3.
REQ-010 i_rs1, i_rs2  in  XLEN each  MDU operands.
REQ-011 o_ALU_Optype  out  4  ALU operation code.
REQ-012 o_stall  out  1  hold the pipeline.
REQ-013 o_md_valid  out  1  one-cycle MDU result strobe.
REQ-014 o_md_result  out  XLEN  MDU result.

Function
REQ-015 o_ALU_Optype shall be combinational: 00->0010; 01->0110; unsupported->1111, never X.
REQ-016 R-type, inst25=0: {inst30,funct3} 0000 add 0010, 1000 sub 0110, 0111 and 0000, 0110 or 0001, 0100 xor 0011, 0001 sll 0100, 0101 srl 0101, 1101 sra 0111; other->1111.
REQ-017 I-type: inst30 ignored except funct3=101 (1 sra 0111, 0 srl 0101); funct3 000/111/110/100/001 map as in REQ-016 with inst30=0.
REQ-018 R-type, inst25=1: funct3 000 MUL (low XLEN of product), 011 MULHU (high XLEN, unsigned), 101 DIVU, 111 REMU; o_ALU_Optype=1000; other funct3->1111, no MDU start.
REQ-019 MDU request = i_valid & ALUOp=10 & inst25=1 & legal funct3 & state IDLE & !i_flush.
REQ-020 FSM states IDLE, MUL, DIV, DONE.
REQ-021 IDLE: request latches rs1, rs2, funct3, clears 6-bit-wide-enough step counter; next state MUL (000/011), DIV (101/111); DIV with rs2=0 goes directly to DONE.
REQ-022 MUL: unsigned shift-add, one multiplier bit per cycle, 2*XLEN accumulator; after step XLEN-1 -> DONE.
REQ-023 DIV: unsigned restoring, one quotient bit per cycle; after step XLEN-1 -> DONE.
REQ-024 DONE: o_md_valid=1 for exactly one cycle; next state IDLE unconditionally; no request accepted in DONE.
REQ-025 Latency: request in cycle T -> o_md_valid in cycle T+XLEN+1; divide-by-zero -> T+1.
REQ-026 Divide by zero: DIVU result all ones; REMU result = rs1.
REQ-027 o_stall = request (combinational, cycle T) | state in {MUL, DIV}; o_stall=0 in DONE and IDLE without request.
REQ-028 o_md_result shall update only on entering DONE and hold until next DONE.
REQ-029 i_flush in any state: next state IDLE, no o_md_valid, o_md_result unchanged; o_stall=0 in flush cycle.
REQ-030 i_valid deassertion during MUL/DIV shall not abort the operation.

Reset
REQ-031 i_rst at a clock edge: state IDLE, counter 0, o_md_result 0; o_md_valid 0 and o_stall 0 next cycle.
REQ-032 Reset mid-operation discards the operation; no o_md_valid follows; i_rst dominates i_flush and requests.

Verification
REQ-033 XLEN=64, R-type: {inst30,funct3}=1000 -> 0110; 1101 -> 0111; I-type funct3=000 inst30=1 -> 0010; ALUOp=10 funct3=010 inst25=0 -> 1111.
REQ-034 XLEN=64 MUL rs1=0xFFFF_FFFF_FFFF_FFFF, rs2=2 -> o_stall T..T+64, o_md_valid at T+65, result 0xFFFF_FFFF_FFFF_FFFE; MULHU same operands -> 1.
REQ-035 XLEN=8 DIVU 200/7 -> 28 at T+9; REMU 200/7 -> 4; DIVU 5/0 -> 0xFF at T+1; REMU 5/0 -> 5 at T+1.
REQ-036 XLEN=8 MUL started, i_flush at T+3 -> IDLE at T+4, no o_md_valid, new DIVU accepted at T+4.
REQ-037 XLEN=8 DIVU started, i_rst at T+5 -> o_stall 0 and o_md_valid 0 from T+6, o_md_result 0.
REQ-038 Back-to-back MUL held with i_valid=1 through DONE -> second start only in IDLE cycle after DONE, exactly one o_md_valid per operation.
